decoder_scan: RTL
=================

# decoder_scan

Parametrised, registered N-to-2^N one-hot decoder with enable, a valid/ready address-load port and an auto-scan mode that steps the active output through all 2^N lines with a programmable dwell time. It generalises the combinational 4-to-16 tree decoder for uses that need glitch-free registered select lines:

- display and keypad row multiplexing
- bank and chip-select sequencing

It sits between control logic that supplies addresses and the downstream one-hot enable loads.

## Interface
- N, default 4: address width; output width is 2^N; legal range 1..8.
- DWELL, default 4: cycles each line stays active in scan mode; legal range >= 1.
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- en  in  1  global enable; 0 forces dout to zero and freezes all state.
- mode  in  1  0 = direct decode, 1 = auto-scan.
- load_valid  in  1  load_addr is valid this cycle.
- load_addr  in  N  address to decode (direct mode) or scan start point (scan mode).
- load_ready  out  1  block accepts a load this cycle; combinational, equals en.
- dout  out  2^N  registered one-hot select; all zeros when disabled.
- cur_addr  out  N  registered index currently driven on dout.
- wrap  out  1  registered one-cycle pulse when the scan index wraps from 2^N-1 to 0.

## Operation
- **Reset.** On any edge with rst_n=0:
  - index (cur_addr) = 0, dwell counter = 0, dout = 0, wrap = 0.
  - Reset overrides en, mode and any load in the same cycle.
- **Load handshake.** A load fires on an edge where load_valid=1 and load_ready=1. Once it fires:
  - index = load_addr and the dwell counter is cleared.
  - The load applies in both modes.
  - load_valid while en=0 is ignored; it is not queued.
- **Direct mode (mode=0, en=1).** The index changes only on an accepted load. dout = one-hot(index), where bit i is set iff index == i.
- **Scan mode (mode=1, en=1).** The dwell counter runs 0..DWELL-1. At DWELL-1 it clears and the index increments modulo 2^N.
  - When the index steps from 2^N-1 to 0, wrap = 1 for exactly one cycle; otherwise wrap = 0.
  - A load on the same edge as a dwell expiry wins: index = load_addr, dwell is cleared, no increment, no wrap.
  - A load of address 0 never raises wrap.
- **Disabled (en=0).** dout = 0 from the next edge. Index and dwell counter hold their values; wrap = 0.
  - On re-enable, dout = one-hot(held index) from the next edge, and the dwell count resumes from its held value.
- **Mode change.** Takes effect at the next edge.
  - Scan to direct: freezes the current index and clears the dwell counter.
  - Direct to scan: starts a fresh dwell period at the current index.
- **Output invariant.** dout is always zero-hot or one-hot. It is never multi-hot, including across resets and mode changes.
- **Elaboration.** N outside 1..8 or DWELL < 1 is a fatal error at elaboration.

## Timing
- All outputs except load_ready are registered; no combinational path from inputs to dout, cur_addr or wrap.
- **Load latency.** Load accepted at edge k gives dout = one-hot(load_addr) and cur_addr = load_addr after edge k, i.e. 1 cycle from load_valid assertion.
- **Scan cadence.** After a load, or on entering scan at edge k, the index advances at edges k+DWELL, k+2·DWELL, and so on.
  - Each line is active for exactly DWELL cycles.
  - A full sweep takes 2^N·DWELL cycles.
- **Wrap timing.** wrap is high during the cycle after the edge that sets index = 0 by increment.
- **Enable latency.** en falling at edge k gives dout = 0 after k. en rising at edge k restores dout after k.
- **Reset mid-scan.** Reset mid-scan discards the in-flight dwell count. After reset is released, the first enabled edge drives dout = 0x…01.
- **Throughput.** One load per cycle maximum; back-to-back loads are accepted on consecutive edges, and each one is visible for one cycle.

## Test plan
- **Reset, then direct loads.** Hold rst_n=0 for 2 edges, then release with en=1, mode=0, N=4. Load 0x5, then 0xF on consecutive cycles.
  - Required: dout=0x0000 during reset, then 0x0020, then 0x8000, with cur_addr tracking 5, 15.
- **Scan sweep with wrap.** N=4, DWELL=4, mode=1, load 0xE.
  - Required: dout=0x4000 for 4 cycles, 0x8000 for 4 cycles, then 0x0001 with wrap=1 for exactly that first cycle.
- **Load versus dwell expiry collision.** Issue a load of 0x3 on the dwell-expiry edge while at index 7.
  - Required: dout=0x0008 next, no 0x0100 at any point, wrap=0, and 0x0008 held for a full 4 cycles.
- **Enable freeze.** In scan at index 2 after 2 dwell cycles, drop en for 5 cycles, then restore it.
  - Required: dout=0 during the gap, load_valid ignored while en=0, then 0x0004 for the remaining 2 cycles before advancing to 0x0008.
- **Reset mid-scan and DWELL=1.** With DWELL=1, assert rst_n=0 for one edge at index 9.
  - Required: dout=0, cur_addr=0, wrap=0; then 0x0001, 0x0002, … stepping every cycle.
- **Mode switch.** Scan to direct at index 6 holds dout=0x0040 indefinitely. Switching back to scan holds 0x0040 for DWELL cycles before moving to 0x0080.

Source files
------------

// File: rtl/decoder_scan.sv
// decoder_scan: registered N-to-2^N one-hot decoder with a valid/ready load port
// and an auto-scan mode that steps through every line with a programmable dwell.
module decoder_scan #(
   parameter int N     = 4,
   parameter int DWELL = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              mode,
   input  logic              load_valid,
   input  logic [N-1:0]      load_addr,
   output logic              load_ready,
   output logic [2**N-1:0]   dout,
   output logic [N-1:0]      cur_addr,
   output logic              wrap
);
   localparam int             CW   = DWELL > 1 ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0]  LAST = CW'(DWELL - 1);
   localparam logic [N-1:0]   TOP  = '1;
   localparam logic [2**N-1:0] ONE = {{(2**N-1){1'b0}}, 1'b1};

   generate
      if (N < 1 || N > 8 || DWELL < 1) begin : g_bad_params
         $fatal(1, "decoder_scan: N must be 1..8 and DWELL >= 1");
      end
   endgenerate

   logic [N-1:0]    idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2**N-1:0] dout_q;
   logic            mode_q, wrap_q, wrap_d, step;

   assign load_ready = en;
   // mode_q low means this edge is the first in scan, so it opens a fresh dwell period
   assign step       = mode && mode_q && cnt_q == LAST;

   always_comb begin
      idx_d  = load_valid ? load_addr : step ? idx_q + 1'b1 : idx_q;
      cnt_d  = (load_valid || !mode || !mode_q || step) ? '0 : cnt_q + 1'b1;
      wrap_d = !load_valid && step && idx_q == TOP;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q  <= '0;
         cnt_q  <= '0;
         mode_q <= 1'b0;
         dout_q <= '0;
         wrap_q <= 1'b0;
      end else if (en) begin
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
         mode_q <= mode;
         dout_q <= ONE << idx_d;
         wrap_q <= wrap_d;
      end else begin
         dout_q <= '0;
         wrap_q <= 1'b0;
      end
   end

   assign dout     = dout_q;
   assign cur_addr = idx_q;
   assign wrap     = wrap_q;
endmodule
